// File: rtl/vga_pat_pkg.sv
// Shared colour constants, 10-entry bar palette and pattern-mode encoding
// for the VGA test-pattern generator.
package vga_pat_pkg;

    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] ORANGE = 16'hFC00;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] CYAN   = 16'h07FF;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] PURPLE = 16'hF81F;
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GRAY   = 16'hD69A;

    localparam int unsigned PAL_NUM = 10;

    // Packed concatenation lists the highest index first: PALETTE[0] is RED.
    localparam logic [PAL_NUM-1:0][15:0] PALETTE = {
        GRAY, WHITE, BLACK, PURPLE, BLUE, CYAN, GREEN, YELLOW, ORANGE, RED
    };

    typedef enum logic [1:0] {
        MODE_VBAR    = 2'd0,
        MODE_HBAR    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_GRAD    = 2'd3
    } vga_mode_e;

    // Bar indices never exceed 15, so one conditional subtract gives mod 10.
    function automatic logic [15:0] pal_lookup(input logic [4:0] idx);
        logic [4:0]  m;
        logic [15:0] c;
        m = (idx >= 5'd10) ? idx - 5'd10 : idx;
        c = BLACK;
        for (int unsigned i = 0; i < PAL_NUM; i++) begin
            if (m == 5'(i)) c = PALETTE[i];
        end
        return c;
    endfunction

    function automatic logic [15:0] grad_color(input logic [4:0] lvl);
        return {lvl, lvl, lvl[4], lvl};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between a VGA timing source (master) and the
// pattern generator (slave).
interface vga_pattern_gen_if;

    logic        pix_valid;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [1:0]  mode_sel;
    logic [15:0] pix_data;
    logic        pix_data_valid;
    logic [1:0]  active_mode;

    modport master (
        output pix_valid, pix_x, pix_y, mode_sel,
        input  pix_data, pix_data_valid, active_mode
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, mode_sel,
        output pix_data, pix_data_valid, active_mode
    );

endinterface

// File: rtl/vga_seg_cnt.sv
// Saturating segment counter: index steps every SEG_LEN advances, stops at
// SEG_NUM-1; idx is the index that applies to the current cycle.
module vga_seg_cnt #(
    parameter int unsigned SEG_LEN = 64,
    parameter int unsigned SEG_NUM = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       advance,
    output logic [4:0] idx
);

    localparam int unsigned CNT_W   = $clog2(SEG_LEN + 1);
    localparam logic [4:0]  IDX_MAX = 5'(SEG_NUM - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
    logic [4:0]       idx_q, idx_d;

    // Restart takes effect on the same cycle, so the restarting pixel sees index 0.
    always_comb begin
        cnt_base = restart ? '0 : cnt_q;
        idx      = restart ? '0 : idx_q;
        cnt_inc  = cnt_base + 1'b1;
        cnt_d    = cnt_base;
        idx_d    = idx;
        if (advance) begin
            if (cnt_inc == CNT_W'(SEG_LEN)) begin
                cnt_d = '0;
                if (idx != IDX_MAX) idx_d = idx + 5'd1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: bars, checkerboard and grey ramp, 1-cycle latency.
// Optional white border overlay when VGA_PAT_BORDER_EN is defined.
module vga_pattern_gen
    import vga_pat_pkg::*;
#(
    parameter logic [11:0] H_VALID  = 12'd640,
    parameter logic [11:0] V_VALID  = 12'd480,
    parameter int unsigned BAR_NUM  = 10,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        pix_valid,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [1:0]  mode_sel,
    output logic [15:0] pix_data,
    output logic        pix_data_valid,
    output logic [1:0]  active_mode
);

    localparam int unsigned BAR_W  = H_VALID / BAR_NUM;
    localparam int unsigned BAR_H  = V_VALID / BAR_NUM;
    localparam int unsigned GRAD_W = H_VALID / 32;
    localparam logic [11:0] H_LAST = H_VALID - 12'd1;

    logic        in_range, pix_ok, line_start, frame_start, line_end;
    logic [4:0]  h_idx, v_idx, g_idx;
    logic [15:0] color;
    vga_mode_e   mode_cur;

    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_data_valid_q, pix_data_valid_d;
    logic [1:0]  active_mode_q, active_mode_d;

    // Out-of-range pixels are treated as invisible: no counter moves.
    always_comb begin
        in_range    = (pix_x < H_VALID) && (pix_y < V_VALID);
        pix_ok      = pix_valid && in_range;
        line_start  = pix_ok && (pix_x == '0);
        frame_start = line_start && (pix_y == '0);
        line_end    = pix_ok && (pix_x == H_LAST);
    end

    vga_seg_cnt #(.SEG_LEN(BAR_W), .SEG_NUM(BAR_NUM)) u_h_cnt (
        .clk     (vga_clk),
        .rst     (sys_rst),
        .restart (line_start),
        .advance (pix_ok),
        .idx     (h_idx)
    );

    vga_seg_cnt #(.SEG_LEN(BAR_H), .SEG_NUM(BAR_NUM)) u_v_cnt (
        .clk     (vga_clk),
        .rst     (sys_rst),
        .restart (frame_start),
        .advance (line_end),
        .idx     (v_idx)
    );

    vga_seg_cnt #(.SEG_LEN(GRAD_W), .SEG_NUM(32)) u_g_cnt (
        .clk     (vga_clk),
        .rst     (sys_rst),
        .restart (line_start),
        .advance (pix_ok),
        .idx     (g_idx)
    );

    // The mode latched at frame start already governs the frame-start pixel.
    always_comb begin
        active_mode_d = frame_start ? mode_sel : active_mode_q;
        mode_cur      = vga_mode_e'(active_mode_d);

        case (mode_cur)
            MODE_VBAR:    color = pal_lookup(h_idx);
            MODE_HBAR:    color = pal_lookup(v_idx);
            MODE_CHECKER: color = (pix_x[CHK_LOG2] ^ pix_y[CHK_LOG2]) ? WHITE : BLACK;
            MODE_GRAD:    color = grad_color(g_idx);
            default:      color = BLACK;
        endcase

`ifdef VGA_PAT_BORDER_EN
        if ((pix_x == '0) || (pix_x == H_LAST) ||
            (pix_y == '0) || (pix_y == V_VALID - 12'd1)) begin
            color = WHITE;
        end
`endif

        pix_data_d       = pix_ok ? color : BLACK;
        pix_data_valid_d = pix_valid;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pix_data_q       <= '0;
            pix_data_valid_q <= 1'b0;
            active_mode_q    <= '0;
        end else begin
            pix_data_q       <= pix_data_d;
            pix_data_valid_q <= pix_data_valid_d;
            active_mode_q    <= active_mode_d;
        end
    end

    assign pix_data       = pix_data_q;
    assign pix_data_valid = pix_data_valid_q;
    assign active_mode    = active_mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: default instance plus a BAR_NUM=7
// instance fed the same pixel stream.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

    logic vga_clk = 1'b0;
    logic sys_rst;
    always #5 vga_clk = ~vga_clk;

    vga_pattern_gen_if vif_a ();
    vga_pattern_gen_if vif_b ();

    assign vif_b.pix_valid = vif_a.pix_valid;
    assign vif_b.pix_x     = vif_a.pix_x;
    assign vif_b.pix_y     = vif_a.pix_y;
    assign vif_b.mode_sel  = vif_a.mode_sel;

    vga_pattern_gen dut_a (
        .vga_clk        (vga_clk),
        .sys_rst        (sys_rst),
        .pix_valid      (vif_a.pix_valid),
        .pix_x          (vif_a.pix_x),
        .pix_y          (vif_a.pix_y),
        .mode_sel       (vif_a.mode_sel),
        .pix_data       (vif_a.pix_data),
        .pix_data_valid (vif_a.pix_data_valid),
        .active_mode    (vif_a.active_mode)
    );

    vga_pattern_gen #(.BAR_NUM(7)) dut_b (
        .vga_clk        (vga_clk),
        .sys_rst        (sys_rst),
        .pix_valid      (vif_b.pix_valid),
        .pix_x          (vif_b.pix_x),
        .pix_y          (vif_b.pix_y),
        .mode_sel       (vif_b.mode_sel),
        .pix_data       (vif_b.pix_data),
        .pix_data_valid (vif_b.pix_data_valid),
        .active_mode    (vif_b.active_mode)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
        logic [1:0]  m;
        bit          care;
        int          x;
        int          y;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_mode = 2'd0;

    function automatic logic [15:0] pal(input int i);
        case (i)
            0: return 16'hF800;
            1: return 16'hFC00;
            2: return 16'hFFE0;
            3: return 16'h07E0;
            4: return 16'h07FF;
            5: return 16'h001F;
            6: return 16'hF81F;
            7: return 16'h0000;
            8: return 16'hFFFF;
            9: return 16'hD69A;
            default: return 16'h0000;
        endcase
    endfunction

    // Reference colour from the coordinates alone (640x480 frame).
    function automatic logic [15:0] model(input logic [1:0] mode, input int x, input int y, input int bn);
        int         idx;
        int         l;
        logic [4:0] lv;
        if (x >= 640 || y >= 480) return 16'h0000;
`ifdef VGA_PAT_BORDER_EN
        if (x == 0 || x == 639 || y == 0 || y == 479) return 16'hFFFF;
`endif
        case (mode)
            2'd0: begin
                idx = x / (640 / bn);
                if (idx > bn - 1) idx = bn - 1;
                return pal(idx % 10);
            end
            2'd1: begin
                idx = y / (480 / bn);
                if (idx > bn - 1) idx = bn - 1;
                return pal(idx % 10);
            end
            2'd2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: begin
                l = x / 20;
                if (l > 31) l = 31;
                lv = 5'(l);
                return {lv, lv, lv[4], lv};
            end
        endcase
    endfunction

    task automatic drive(input bit v, input int x, input int y, input bit care);
        exp_t e;
        @(negedge vga_clk);
        sys_rst         = 1'b0;
        vif_a.pix_valid = v;
        vif_a.pix_x     = 12'(x);
        vif_a.pix_y     = 12'(y);
        if (v && x == 0 && y == 0) exp_mode = vif_a.mode_sel;
        e.v    = v;
        e.m    = exp_mode;
        e.care = care;
        e.x    = x;
        e.y    = y;
        e.a    = v ? model(exp_mode, x, y, 10) : 16'h0000;
        e.b    = v ? model(exp_mode, x, y, 7)  : 16'h0000;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b1);
    endtask

    task automatic full_line(input int y);
        for (int x = 0; x < 640; x++) drive(1'b1, x, y, 1'b1);
        idle(1);
    endtask

    // Only the first pixels and the line end: enough to clock the vertical counter.
    task automatic sparse_line(input int y);
        for (int x = 0; x < 3; x++) drive(1'b1, x, y, 1'b1);
        drive(1'b1, 639, y, (exp_mode == 2'd1) || (exp_mode == 2'd2));
        idle(1);
    endtask

    task automatic pulse_rst(input int n, input int x0, input int y);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk);
            sys_rst         = 1'b1;
            vif_a.pix_valid = 1'b1;
            vif_a.pix_x     = 12'(x0 + i);
            vif_a.pix_y     = 12'(y);
            exp_mode        = 2'd0;
            e.v    = 1'b0;
            e.m    = 2'd0;
            e.care = 1'b1;
            e.x    = x0 + i;
            e.y    = y;
            e.a    = 16'h0000;
            e.b    = 16'h0000;
            sb.push_back(e);
        end
    endtask

    always begin
        @(posedge vga_clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (vif_a.pix_data_valid !== mon_e.v) begin
                errors++;
                $display("FAIL valid_a (x=%0d y=%0d) got %b exp %b", mon_e.x, mon_e.y, vif_a.pix_data_valid, mon_e.v);
            end
            checks++;
            if (vif_a.active_mode !== mon_e.m) begin
                errors++;
                $display("FAIL mode_a (x=%0d y=%0d) got %0d exp %0d", mon_e.x, mon_e.y, vif_a.active_mode, mon_e.m);
            end
            checks++;
            if (vif_b.pix_data_valid !== mon_e.v) begin
                errors++;
                $display("FAIL valid_b (x=%0d y=%0d) got %b exp %b", mon_e.x, mon_e.y, vif_b.pix_data_valid, mon_e.v);
            end
            if (mon_e.care) begin
                checks++;
                if (vif_a.pix_data !== mon_e.a) begin
                    errors++;
                    $display("FAIL data_a (x=%0d y=%0d mode=%0d) got %h exp %h", mon_e.x, mon_e.y, mon_e.m, vif_a.pix_data, mon_e.a);
                end
                checks++;
                if (vif_b.pix_data !== mon_e.b) begin
                    errors++;
                    $display("FAIL data_b7 (x=%0d y=%0d mode=%0d) got %h exp %h", mon_e.x, mon_e.y, mon_e.m, vif_b.pix_data, mon_e.b);
                end
            end
        end
    end

    task automatic test_reset();
        vif_a.mode_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            sys_rst         = 1'b1;
            vif_a.pix_valid = 1'b1;
            vif_a.pix_x     = 12'd0;
            vif_a.pix_y     = 12'd0;
            @(posedge vga_clk);
            #1;
            checks++;
            if (vif_a.pix_data !== 16'h0000 || vif_a.pix_data_valid !== 1'b0 || vif_a.active_mode !== 2'd0) begin
                errors++;
                $display("FAIL reset_state got data=%h valid=%b mode=%0d exp 0000/0/0",
                         vif_a.pix_data, vif_a.pix_data_valid, vif_a.active_mode);
            end
        end
        exp_mode = 2'd0;
        idle(2);
    endtask

    task automatic test_vbar();
        vif_a.mode_sel = 2'd0;
        for (int x = 0; x < 640; x++) begin
            if (x == 200) idle(1);
            if (x == 400) drive(1'b1, 700, 0, 1'b1);
            drive(1'b1, x, 0, 1'b1);
        end
        idle(1);
        full_line(1);
        full_line(2);
    endtask

    task automatic test_hbar();
        vif_a.mode_sel = 2'd1;
        full_line(0);
        for (int y = 1; y < 480; y++) sparse_line(y);
    endtask

    task automatic test_mode_switch();
        vif_a.mode_sel = 2'd0;
        full_line(0);
        for (int y = 1; y < 100; y++) sparse_line(y);
        vif_a.mode_sel = 2'd2;
        for (int y = 100; y < 111; y++) sparse_line(y);
        full_line(111);
        full_line(0);
        for (int y = 1; y < 32; y++) sparse_line(y);
        full_line(32);
        checks++;
        if (vif_a.active_mode !== 2'd2) begin
            errors++;
            $display("FAIL mode_after_switch got %0d exp 2", vif_a.active_mode);
        end
    endtask

    task automatic test_grad();
        vif_a.mode_sel = 2'd3;
        full_line(0);
        full_line(1);
    endtask

    task automatic test_reset_midline();
        vif_a.mode_sel = 2'd3;
        full_line(0);
        for (int y = 1; y < 50; y++) sparse_line(y);
        for (int x = 0; x < 300; x++) drive(1'b1, x, 50, 1'b1);
        pulse_rst(2, 300, 50);
        idle(2);
        for (int x = 302; x < 640; x++) drive(1'b1, x, 50, 1'b0);
        idle(1);
        full_line(51);
    endtask

    task automatic test_border();
        vif_a.mode_sel = 2'd2;
        drive(1'b1, 0, 0, 1'b1);
        idle(1);
        drive(1'b1, 0, 200, 1'b1);
        drive(1'b1, 639, 479, 1'b1);
        drive(1'b1, 1, 1, 1'b1);
        drive(1'b1, 32, 0, 1'b1);
        drive(1'b1, 32, 32, 1'b1);
        drive(1'b1, 639, 400, 1'b1);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst         = 1'b1;
        vif_a.pix_valid = 1'b0;
        vif_a.pix_x     = 12'd0;
        vif_a.pix_y     = 12'd0;
        vif_a.mode_sel  = 2'd0;
        test_reset();
        test_vbar();
        test_hbar();
        test_mode_switch();
        test_grad();
        test_reset_midline();
        test_border();
        repeat (3) @(posedge vga_clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_VALID, default 12'd640, active pixels per line.
REQ-002 Parameter V_VALID, default 12'd480, active lines per frame.
REQ-003 Parameter BAR_NUM, default 10, bar count, legal range 2..16.
REQ-004 Parameter CHK_LOG2, default 5, checker square side is 2^CHK_LOG2 pixels.
REQ-005 Port vga_clk, input, 1 bit, the only clock for all logic.
REQ-006 Port sys_rst, input, 1 bit, reset, synchronous to vga_clk and active-high.
REQ-007 Port pix_valid, input, 1 bit, the current pix_x/pix_y is an active-area pixel.
REQ-008 Port pix_x, input, 12 bits, pixel X coordinate.
REQ-009 Port pix_y, input, 12 bits, pixel Y coordinate.
REQ-010 Port mode_sel, input, 2 bits, requested pattern mode.
REQ-011 Port pix_data, output, 16 bits, RGB565 pixel colour.
REQ-012 Port pix_data_valid, output, 1 bit, pix_data carries a pixel.
REQ-013 Port active_mode, output, 2 bits, mode currently applied.

Function
REQ-014 Latency is exactly 1 cycle: pix_data and pix_data_valid reflect the inputs of the previous cycle; pix_data_valid equals pix_valid delayed by one cycle.
REQ-015 Any cycle with pix_valid low shall produce pix_data of 16'h0000 on the next cycle.
REQ-016 Frame start is pix_valid high with pix_x==0 and pix_y==0.
  - On frame start, mode_sel is latched into active_mode.
  - The new mode also applies to that frame-start pixel.
  - mode_sel changes at any other time have no effect.
REQ-017 The horizontal segment index is a counter, with no runtime divide.
  - Bar width W = H_VALID/BAR_NUM, integer division at elaboration.
  - The index restarts at 0 on a valid pixel with pix_x==0.
  - The index increments after each W valid pixels.
  - The index saturates at BAR_NUM-1, so the last bar absorbs the remainder.
REQ-018 The vertical segment index behaves the same way, with these differences:
  - It uses height V_VALID/BAR_NUM.
  - It advances once per line, on the valid pixel with pix_x==H_VALID-1.
  - It restarts at frame start.
REQ-019 The gradient level is a third counter: 32 segments of H_VALID/32 pixels, restart at pix_x==0, saturating at 31.
REQ-020 Mode 0, vertical bars: colour is palette[horizontal index mod 10].
REQ-021 Mode 1, horizontal bars: colour is palette[vertical index mod 10].
REQ-022 Mode 2, checkerboard: WHITE when pix_x[CHK_LOG2] XOR pix_y[CHK_LOG2] is 1, else BLACK.
REQ-023 Mode 3, grey ramp: with L = gradient level, pix_data = {L[4:0], L[4:0], L[4], L[4:0]}.
REQ-024 Palette order, indices 0..9: RED F800, ORANGE FC00, YELLOW FFE0, GREEN 07E0, CYAN 07FF, BLUE 001F, PURPLE F81F, BLACK 0000, WHITE FFFF, GRAY D69A.
REQ-025 A valid pixel with pix_x>=H_VALID or pix_y>=V_VALID outputs BLACK and does not advance any counter.
REQ-026 Counters assume pix_x increments by 1 per valid cycle within a line.
  - A discontinuity is not corrected until the next pix_x==0.
  - pix_x==0 always forces horizontal resync, including mid-line.

Reset
REQ-027 While sys_rst is high, on each vga_clk edge:
  - pix_data = 16'h0000, pix_data_valid = 0, active_mode = 2'd0.
  - All segment counters and indices = 0.
REQ-028 Reset asserted mid-line or mid-frame discards state.
  - After release, output is BLACK with valid low until pix_valid returns.
  - Bars are correct from the next pix_x==0.

Configuration
REQ-029 Macro VGA_PAT_BORDER_EN enables a border overlay.
  - Defined: a valid pixel with pix_x==0, pix_x==H_VALID-1, pix_y==0 or pix_y==V_VALID-1 outputs WHITE in every mode, overriding the pattern.
  - Undefined: no border logic is present and patterns are unmodified.

Structure
REQ-030 Package vga_pat_pkg holds the 16-bit colour constants, the 10-entry palette, and the mode encoding (VBAR=0, HBAR=1, CHECKER=2, GRAD=3).
REQ-031 Sub-module vga_seg_cnt is parameterised by segment length and segment count.
  - Inputs: restart, advance.
  - Output: saturating index.
  - It is instantiated three times: horizontal, vertical, gradient.

Verification
REQ-032 Scenario, default parameters, mode 0, full frame:
  - x=63 gives F800; x=64 gives FC00; x=639 gives D69A.
  - pix_data_valid lags pix_valid by 1 cycle.
REQ-033 Scenario, BAR_NUM=7, mode 0: W=91; x=545 gives 001F; x=546..639 give F81F (saturated last bar).
REQ-034 Scenario, mode_sel changed 0 to 2 at line 100: the rest of that frame stays bars; next frame, pixel (32,0) is FFFF and (32,32) is 0000.
REQ-035 Scenario, mode 3: x=0 gives 0000; x=20 gives 0841; x=639 gives FFFF.
REQ-036 Scenario, sys_rst pulsed for 2 cycles at x=300 of line 50:
  - Outputs are 0 and active_mode is 0 during reset.
  - Next line x=0..63 gives F800.
REQ-037 Scenario, VGA_PAT_BORDER_EN defined, mode 2: pixel (0,200) and (639,479) give FFFF; pixel (1,1) follows the checker.
